// File: rtl/jk_count_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_seq_pkg
// Description : Shared types and defaults for the JK count sequencer: command
//               op encoding, FSM state encoding, default bank/length widths.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_UP    = 2'd2,
    OP_DOWN  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/jk_count_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_count_sequencer_if
// Description : Command valid/ready channel between a host and the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_count_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/jk_count_sequencer_bank.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank
// Description : Bank of WIDTH generic JK flip-flops, async active-low reset.
//               Per bit: JK=00 hold, 01 reset, 10 set, 11 toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] j_i,
  input  wire logic [WIDTH-1:0] k_i,
  output logic      [WIDTH-1:0] q_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_q;

    // One JK flop: classic four-way next-state table
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        bit_q <= 1'b0;
      end else begin
        case ({j_i[i], k_i[i]})
          2'b01:   bit_q <= 1'b0;
          2'b10:   bit_q <= 1'b1;
          2'b11:   bit_q <= ~bit_q;
          default: bit_q <= bit_q;
        endcase
      end
    end

    assign q_o[i] = bit_q;
  end

endmodule
`default_nettype wire

// File: rtl/jk_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_count_sequencer
// Description : Accepts CLEAR/LOAD/UP/DOWN commands over valid/ready and
//               drives J/K of a jk_bank each cycle until the command is done.
//               Optional saturation build: define JK_SEQ_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_count_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  wire logic       clk,
  input  wire logic       rst,
  jk_count_sequencer_if.slave cmd,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] data_q;
  logic             accept;
  logic [WIDTH-1:0] jk_j, jk_k;
  logic             sat_hold;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state, remaining-count and handshake decode
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          accept = 1'b1;
          len_d  = cmd.cmd_len;
          // Counting with zero length has nothing to do; report completion
          if ((op_e'(cmd.cmd_op) == OP_UP || op_e'(cmd.cmd_op) == OP_DOWN) &&
              (cmd.cmd_len == '0))
            state_d = ST_DONE;
          else
            state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        len_d = len_q - 1'b1;
        if (op_q == OP_CLEAR || op_q == OP_LOAD || len_q == CNT_W'(1))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

  // Command latch; fields are captured once so the host may change them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_CLEAR;
      data_q <= '0;
      len_q  <= '0;
    end else begin
      len_q <= len_d;
      if (accept) begin
        op_q   <= op_e'(cmd.cmd_op);
        data_q <= cmd.cmd_data;
      end
    end
  end

`ifdef JK_SEQ_SAT_EN
  // Counting would wrap: hold the bank instead
  assign sat_hold = (state_q == ST_RUN) &&
                    ((op_q == OP_UP   && (&q)) ||
                     (op_q == OP_DOWN && ~(|q)));

  logic sat_q;

  // Sticky saturation flag, cleared when the next command is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          sat_q <= 1'b0;
    else if (accept)   sat_q <= 1'b0;
    else if (sat_hold) sat_q <= 1'b1;
  end

  assign sat = sat_q;
`else
  assign sat_hold = 1'b0;
  assign sat      = 1'b0;
`endif

  // J/K generation: ripple-counter toggle enables derived from current q
  always_comb begin
    logic ones;
    logic zeros;
    jk_j  = '0;
    jk_k  = '0;
    ones  = 1'b1;
    zeros = 1'b1;
    if (state_q == ST_RUN && !sat_hold) begin
      case (op_q)
        OP_CLEAR: jk_k = {WIDTH{1'b1}};
        OP_LOAD: begin
          jk_j = data_q;
          jk_k = ~data_q;
        end
        OP_UP: begin
          for (int i = 0; i < WIDTH; i++) begin
            jk_j[i] = ones;
            jk_k[i] = ones;
            ones    = ones & q[i];
          end
        end
        OP_DOWN: begin
          for (int i = 0; i < WIDTH; i++) begin
            jk_j[i] = zeros;
            jk_k[i] = zeros;
            zeros   = zeros & ~q[i];
          end
        end
        default: begin
          jk_j = '0;
          jk_k = '0;
        end
      endcase
    end
  end

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .rst (rst),
    .j_i (jk_j),
    .k_i (jk_k),
    .q_o (q)
  );

endmodule
`default_nettype wire

// File: tb/tb_jk_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_count_sequencer
// Description : Self-checking bench for jk_count_sequencer with a numeric
//               counter model. Saturation expectations follow JK_SEQ_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_count_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam logic [31:0] MAX = (32'd1 << WIDTH) - 32'd1;

  logic clk;
  logic rst;
  logic [WIDTH-1:0] q;
  logic busy, done, sat;

  jk_count_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  jk_count_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (bus),
    .q    (q),
    .busy (busy),
    .done (done),
    .sat  (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_q   = 0;
  logic        m_sat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_busy,
                               input logic e_done, input logic e_ready);
    check({tag, ".q"},     32'(q),             m_q);
    check({tag, ".busy"},  32'(busy),          32'(e_busy));
    check({tag, ".done"},  32'(done),          32'(e_done));
    check({tag, ".ready"}, 32'(bus.cmd_ready), 32'(e_ready));
    check({tag, ".sat"},   32'(sat),           32'(m_sat));
  endtask

  // Reference: one counting step expressed as plain modular arithmetic
  task automatic model_step(input int op, input logic [31:0] data);
    case (op)
      0: m_q = 0;
      1: m_q = data & MAX;
      2: begin
`ifdef JK_SEQ_SAT_EN
        if (m_q == MAX) m_sat = 1'b1;
        else            m_q = (m_q + 1) & MAX;
`else
        m_q = (m_q + 1) & MAX;
`endif
      end
      default: begin
`ifdef JK_SEQ_SAT_EN
        if (m_q == 0) m_sat = 1'b1;
        else          m_q = (m_q - 1) & MAX;
`else
        m_q = (m_q - 1) & MAX;
`endif
      end
    endcase
  endtask

  // Issue one command from idle (called at a negedge) and follow it to idle
  task automatic do_cmd(input int op, input int len, input logic [31:0] data,
                        input bit hold);
    int n;
    check("pre.ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_len   = CNT_W'(len);
    bus.cmd_data  = WIDTH'(data);
    @(posedge clk); @(negedge clk);
    m_sat = 1'b0;
    if (!hold) bus.cmd_valid = 1'b0;
    n = (op < 2) ? 1 : len;
    check_outputs("accept", 1'b1, n == 0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); @(negedge clk);
      model_step(op, data);
      check_outputs("run", 1'b1, k == n, 1'b0);
    end
    @(posedge clk); @(negedge clk);
    check_outputs("end", 1'b0, 1'b0, 1'b1);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int r;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    @(negedge clk);
    check_outputs("reset", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs("post_reset", 1'b0, 1'b0, 1'b1);

    // LOAD, wrap-around UP, wrap-around DOWN
    do_cmd(1, 0, 32'hA, 1'b0);
    do_cmd(1, 0, 32'hE, 1'b0);
    do_cmd(2, 3, 0, 1'b0);
    do_cmd(1, 0, 32'h1, 1'b0);
    do_cmd(3, 2, 0, 1'b0);

    // Zero-length UP with valid held: must not be taken twice
    do_cmd(2, 0, 0, 1'b1);
    @(negedge clk);
    check_outputs("no_reaccept", 1'b0, 1'b0, 1'b1);

    // Long UP aborted by reset
    do_cmd(1, 0, 32'h3, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_len   = CNT_W'(200);
    @(posedge clk); @(negedge clk);
    m_sat = 1'b0;
    bus.cmd_valid = 1'b0;
    r = $urandom_range(5, 40);
    for (int k = 0; k < r; k++) begin
      @(posedge clk); @(negedge clk);
      model_step(2, 0);
      check_outputs("long_run", 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b0;
    #1;
    m_q = 0; m_sat = 1'b0;
    check_outputs("abort", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_outputs("after_abort", 1'b0, 1'b0, 1'b1);
    end

    // Back-to-back with valid held high
    do_cmd(0, 0, 0, 1'b1);
    do_cmd(1, 0, 32'h5, 1'b1);
    do_cmd(2, 1, 0, 1'b1);

    // Randomized command stream
    for (int t = 0; t < 60; t++) begin
      int op, len, gap;
      op  = int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 20));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_outputs("gap", 1'b0, 1'b0, 1'b1);
      end
      do_cmd(op, len, 32'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
